// File: rtl/packet_generator.sv
// packet_generator: Avalon-ST test packet source with an Avalon-MM register file.
// Each packet carries a running byte count (byte i = i[7:0]) with a programmable
// PAT_WORDS*4-byte pattern overlaid at a programmable byte offset.
//
// Ports:
//   clk_i, srst_i            clock, asynchronous active-high reset
//   amm_address_i ...        Avalon-MM slave: address, write, writedata, read
//   amm_readdata_o/_valid_o  registered read data, valid one cycle after read
//   src_ready_i              Avalon-ST ready (readyLatency 0)
//   src_data_o ... _channel_o Avalon-ST source: data (big-endian), valid, sop, eop,
//                            empty, channel
module packet_generator #(
    parameter int unsigned AMM_DWIDTH    = 32,
    parameter int unsigned AST_DWIDTH    = 64,
    parameter int unsigned CHANNEL_WIDTH = 1,
    parameter int unsigned PAT_WORDS     = 3,
    parameter int unsigned LEN_WIDTH     = 16
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic [2:0]                        amm_address_i,
    input  logic                              amm_write_i,
    input  logic [AMM_DWIDTH-1:0]             amm_writedata_i,
    input  logic                              amm_read_i,
    output logic [AMM_DWIDTH-1:0]             amm_readdata_o,
    output logic                              amm_readdatavalid_o,
    input  logic                              src_ready_i,
    output logic [AST_DWIDTH-1:0]             src_data_o,
    output logic                              src_valid_o,
    output logic                              src_startofpacket_o,
    output logic                              src_endofpacket_o,
    output logic [$clog2(AST_DWIDTH/8)-1:0]   src_empty_o,
    output logic [CHANNEL_WIDTH-1:0]          src_channel_o
);

    localparam int unsigned BPW       = AST_DWIDTH / 8;
    localparam int unsigned EMPTY_W   = $clog2(BPW);
    localparam int unsigned PAT_BYTES = PAT_WORDS * (AMM_DWIDTH / 8);
    localparam int unsigned PAT_BITS  = PAT_WORDS * AMM_DWIDTH;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [LEN_WIDTH-1:0]     len_q, offset_q, count_q, sent_q, word_q;
    logic [CHANNEL_WIDTH-1:0] channel_q;
    // Pattern word 0 occupies the top bits so pattern byte 0 is the MSB byte.
    logic [PAT_BITS-1:0]      pat_q;
    logic                     abort_pend_q;
    logic [AMM_DWIDTH-1:0]    rdata_q, rdata_d;
    logic                     rvalid_q;

    logic                     busy, wr_ctrl, start_req, abort_req, start_ok, abort_any;
    logic                     fire, is_last, last_fire, more;
    logic [LEN_WIDTH-1:0]     last_word, sent_inc;
    logic [EMPTY_W-1:0]       empty_val;
    logic [AST_DWIDTH-1:0]    word_data;
    logic                     unused_wdata;

    assign busy      = (state_q != StIdle);
    assign wr_ctrl   = amm_write_i && (amm_address_i == 3'd0);
    assign start_req = wr_ctrl && amm_writedata_i[0];
    assign abort_req = wr_ctrl && amm_writedata_i[1];
    assign start_ok  = start_req && !busy && (len_q != '0) && (count_q != '0);
    assign abort_any = abort_pend_q || abort_req;

    // LEN is non-zero whenever a packet is in flight, so len-1 never wraps there.
    assign last_word = (len_q - LEN_WIDTH'(1)) >> EMPTY_W;
    assign is_last   = (word_q == last_word);
    // Unused bytes in the last word = (-LEN) mod bytes-per-word.
    assign empty_val = EMPTY_W'('0 - len_q);

    assign src_valid_o = (state_q == StSend);
    assign fire        = src_valid_o && src_ready_i;
    assign last_fire   = fire && is_last;
    assign sent_inc    = (sent_q == '1) ? sent_q : sent_q + LEN_WIDTH'(1);
    assign more        = ({1'b0, sent_q} + (LEN_WIDTH + 1)'(1)) < {1'b0, count_q};

    assign unused_wdata = ^amm_writedata_i;

    // Payload of the current word: running byte count, pattern overlay, zero past LEN.
    always_comb begin
        logic [31:0] bidx;
        logic [7:0]  b;
        word_data = '0;
        for (int unsigned j = 0; j < BPW; j++) begin
            bidx = 32'(word_q) * BPW + j;
            b    = bidx[7:0];
            for (int unsigned k = 0; k < PAT_BYTES; k++) begin
                if (bidx == 32'(offset_q) + k) begin
                    b = pat_q[PAT_BITS-1-8*k -: 8];
                end
            end
            if (bidx >= 32'(len_q)) begin
                b = 8'h00;
            end
            word_data[AST_DWIDTH-1-8*j -: 8] = b;
        end
    end

    assign src_data_o          = src_valid_o ? word_data : '0;
    assign src_startofpacket_o = src_valid_o && (word_q == '0);
    assign src_endofpacket_o   = src_valid_o && is_last;
    assign src_empty_o         = (src_valid_o && is_last) ? empty_val : '0;
    assign src_channel_o       = src_valid_o ? channel_q : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start_ok) state_d = StSend;
            StSend: if (last_fire) state_d = (more && !abort_any) ? StGap : StIdle;
            StGap:  state_d = abort_any ? StIdle : StSend;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (amm_address_i)
            3'd0: begin
                rdata_d[2]                 = busy;
                rdata_d[8 +: CHANNEL_WIDTH] = channel_q;
            end
            3'd1: begin
                rdata_d[0 +: LEN_WIDTH]  = len_q;
                rdata_d[16 +: LEN_WIDTH] = offset_q;
            end
            3'd5: rdata_d[0 +: LEN_WIDTH] = count_q;
            3'd6: rdata_d[0 +: LEN_WIDTH] = sent_q;
            default: ;
        endcase
        for (int unsigned k = 0; k < PAT_WORDS; k++) begin
            if (amm_address_i == 3'(k + 2)) begin
                rdata_d = pat_q[PAT_BITS-1-AMM_DWIDTH*k -: AMM_DWIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q      <= StIdle;
            len_q        <= '0;
            offset_q     <= '0;
            count_q      <= '0;
            sent_q       <= '0;
            word_q       <= '0;
            channel_q    <= '0;
            pat_q        <= '0;
            abort_pend_q <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= amm_read_i;
            if (amm_read_i) rdata_q <= rdata_d;

            if (start_ok) begin
                word_q <= '0;
                sent_q <= '0;
            end else if (fire) begin
                word_q <= is_last ? '0 : word_q + LEN_WIDTH'(1);
                if (is_last) sent_q <= sent_inc;
            end

            // An abort is remembered only while a run is active and is dropped on
            // every return to IDLE.
            if (state_d == StIdle) begin
                abort_pend_q <= 1'b0;
            end else if (abort_req && busy) begin
                abort_pend_q <= 1'b1;
            end

            if (amm_write_i && !busy) begin
                case (amm_address_i)
                    3'd0: channel_q <= amm_writedata_i[8 +: CHANNEL_WIDTH];
                    3'd1: begin
                        len_q    <= amm_writedata_i[0 +: LEN_WIDTH];
                        offset_q <= amm_writedata_i[16 +: LEN_WIDTH];
                    end
                    3'd5: count_q <= amm_writedata_i[0 +: LEN_WIDTH];
                    default: ;
                endcase
                for (int unsigned k = 0; k < PAT_WORDS; k++) begin
                    if (amm_address_i == 3'(k + 2)) begin
                        pat_q[PAT_BITS-1-AMM_DWIDTH*k -: AMM_DWIDTH] <= amm_writedata_i;
                    end
                end
            end
        end
    end

    assign amm_readdata_o      = rdata_q;
    assign amm_readdatavalid_o = rvalid_q;

endmodule

// File: tb/tb_packet_generator.sv
// Testbench for packet_generator: directed register programming, a byte-level
// packet model feeding an expected-beat queue, and a per-cycle output checker.
module tb_packet_generator;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic [2:0]  amm_address = '0;
    logic        amm_write = 1'b0;
    logic [31:0] amm_writedata = '0;
    logic        amm_read = 1'b0;
    logic [31:0] amm_readdata;
    logic        amm_readdatavalid;
    logic        src_ready = 1'b0;
    logic [63:0] src_data;
    logic        src_valid, src_sop, src_eop;
    logic [2:0]  src_empty;
    logic [0:0]  src_channel;

    always #5 clk_i = ~clk_i;

    packet_generator dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .amm_address_i       (amm_address),
        .amm_write_i         (amm_write),
        .amm_writedata_i     (amm_writedata),
        .amm_read_i          (amm_read),
        .amm_readdata_o      (amm_readdata),
        .amm_readdatavalid_o (amm_readdatavalid),
        .src_ready_i         (src_ready),
        .src_data_o          (src_data),
        .src_valid_o         (src_valid),
        .src_startofpacket_o (src_sop),
        .src_endofpacket_o   (src_eop),
        .src_empty_o         (src_empty),
        .src_channel_o       (src_channel)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        ch;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          passed = 0;
    int          ready_mode = 1;  // 0: ready low, 1: ready high, 2: random
    int          sop_seen = 0;
    int          m_len, m_off;
    logic [7:0]  m_pat [12];
    logic        m_ch;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference packets built byte by byte from the payload rules.
    task automatic push_pkts(input int n);
        int    nw;
        int    i;
        beat_t b;
        logic [7:0] v;
        nw = (m_len + 7) / 8;
        for (int p = 0; p < n; p++) begin
            for (int w = 0; w < nw; w++) begin
                b = '0;
                for (int j = 0; j < 8; j++) begin
                    i = w * 8 + j;
                    v = 8'h00;
                    if (i < m_len) begin
                        v = 8'(i);
                        if (i >= m_off && i < m_off + 12) v = m_pat[i - m_off];
                    end
                    b.data[63-8*j -: 8] = v;
                end
                b.sop   = (w == 0);
                b.eop   = (w == nw - 1);
                b.empty = (w == nw - 1) ? 3'(nw * 8 - m_len) : 3'd0;
                b.ch    = m_ch;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic amm_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk_i); #1;
        amm_address = a; amm_writedata = d; amm_write = 1'b1;
        @(posedge clk_i); #1;
        amm_write = 1'b0;
    endtask

    task automatic amm_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk_i); #1;
        amm_address = a; amm_read = 1'b1;
        @(posedge clk_i); #1;
        amm_read = 1'b0;
        @(negedge clk_i);
        chk("readdatavalid", amm_readdatavalid, 1);
        d = amm_readdata;
    endtask

    task automatic configure(input int len, input int off, input int cnt, input logic ch,
                             input logic [31:0] p0, input logic [31:0] p1,
                             input logic [31:0] p2);
        logic [95:0] pf;
        m_len = len; m_off = off; m_ch = ch;
        pf = {p0, p1, p2};
        for (int k = 0; k < 12; k++) m_pat[k] = pf[95-8*k -: 8];
        amm_wr(3'd1, {16'(off), 16'(len)});
        amm_wr(3'd2, p0);
        amm_wr(3'd3, p1);
        amm_wr(3'd4, p2);
        amm_wr(3'd5, 32'(cnt));
        amm_wr(3'd0, {23'd0, ch, 8'd0});
    endtask

    task automatic start();
        amm_wr(3'd0, {23'd0, m_ch, 8'h01});
    endtask

    task automatic wait_done(input string name, input int max);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || src_valid) && k < max) begin
            @(negedge clk_i);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_sop(input string name, input int target, input int max);
        int k;
        k = 0;
        while (sop_seen < target && k < max) begin
            @(negedge clk_i);
            k++;
        end
        chk(name, sop_seen, target);
    endtask

    initial forever begin
        @(posedge clk_i); #1;
        case (ready_mode)
            0: src_ready = 1'b0;
            1: src_ready = 1'b1;
            default: src_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Per-cycle checker: beats vs. model, hold during stalls, no bubbles, 1-cycle gap.
    initial begin
        beat_t cur, prev, e;
        logic  stall_prev, in_pkt, expect_gap;
        int    gap;
        stall_prev = 0; in_pkt = 0; expect_gap = 0; gap = 0; prev = '0;
        forever begin
            @(negedge clk_i);
            cur = {src_data, src_sop, src_eop, src_empty, src_channel};
            if (srst_i) begin
                stall_prev = 0; in_pkt = 0; expect_gap = 0; gap = 0;
            end else begin
                if (stall_prev) chk("stall_hold", {src_valid, cur}, {1'b1, prev});
                if (in_pkt) chk("no_bubble", src_valid, 1);
                if (expect_gap) begin
                    if (!src_valid) gap++;
                    else begin
                        chk("gap_cycles", gap, 1);
                        expect_gap = 0;
                    end
                end
                if (src_valid && src_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", src_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", cur, e);
                        if (src_sop) sop_seen++;
                        in_pkt = !src_eop;
                        if (src_eop && exp_q.size() != 0) begin
                            expect_gap = 1;
                            gap = 0;
                        end
                    end
                end
                stall_prev = src_valid && !src_ready;
                prev = cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int base;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_valid", src_valid, 0);
        chk("rst_outputs", {src_data, src_sop, src_eop, src_empty, src_channel}, 0);
        chk("rst_rdv", amm_readdatavalid, 0);
        srst_i = 1'b0;
        amm_rd(3'd1, d); chk("rst_len_off", d, 0);
        amm_rd(3'd6, d); chk("rst_sent", d, 0);
        amm_rd(3'd0, d); chk("rst_ctrl", d, 0);
        amm_rd(3'd7, d); chk("unmapped_read", d, 0);

        // Pattern at offset 0, three beats with a partial last word.
        ready_mode = 1;
        configure(20, 0, 1, 1'b0, 32'h01020304, 32'h05060708, 32'h090A0B0C);
        push_pkts(1);
        chk("model_t1_b0", {exp_q[0].data, exp_q[0].sop}, {64'h0102030405060708, 1'b1});
        chk("model_t1_b1", exp_q[1].data, 64'h090A0B0C0C0D0E0F);
        chk("model_t1_b2", {exp_q[2].data, exp_q[2].eop, exp_q[2].empty},
            {64'h1011121300000000, 1'b1, 3'd4});
        start();
        wait_done("t1_drain", 100);
        amm_rd(3'd6, d); chk("t1_sent", d, 1);
        amm_rd(3'd0, d); chk("t1_ctrl", d, 0);

        // Pattern truncated by LEN; single-beat packet on channel 1.
        m_len = 8;
        configure(8, 4, 1, 1'b1, 32'h01020304, 32'h05060708, 32'h090A0B0C);
        push_pkts(1);
        chk("model_t2", {exp_q[0].data, exp_q[0].sop, exp_q[0].eop, exp_q[0].empty},
            {64'h0001020301020304, 1'b1, 1'b1, 3'd0});
        start();
        wait_done("t2_drain", 100);
        amm_rd(3'd0, d); chk("t2_ctrl", d, 32'h100);

        // Three packets under random backpressure.
        ready_mode = 2;
        configure(16, 2, 3, 1'b0, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4);
        push_pkts(3);
        start();
        wait_done("t3_drain", 300);
        amm_rd(3'd6, d); chk("t3_sent", d, 3);

        // ABORT during the second of five packets.
        ready_mode = 1;
        configure(16, 0, 5, 1'b0, 32'h11223344, 32'h55667788, 32'h99AABBCC);
        push_pkts(2);
        base = sop_seen;
        start();
        wait_sop("t4_sop2", base + 2, 100);
        amm_wr(3'd0, 32'h2);
        wait_done("t4_drain", 100);
        repeat (10) @(negedge clk_i);
        amm_rd(3'd6, d); chk("t4_sent", d, 2);
        amm_rd(3'd0, d); chk("t4_ctrl", d, 0);

        // LEN=0 START is ignored; LEN write while busy is ignored.
        configure(0, 0, 1, 1'b0, 32'h0, 32'h0, 32'h0);
        start();
        repeat (5) @(negedge clk_i);
        chk("t5_no_valid", src_valid, 0);
        amm_rd(3'd0, d); chk("t5_not_busy", d, 0);
        ready_mode = 0;
        configure(16, 0, 2, 1'b0, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF);
        push_pkts(2);
        start();
        repeat (3) @(negedge clk_i);
        amm_rd(3'd0, d); chk("t5_busy", d[2], 1);
        amm_wr(3'd1, 32'h0003_0040);
        amm_rd(3'd1, d); chk("t5_len_locked", d, 32'h0000_0010);
        ready_mode = 1;
        wait_done("t5_drain", 100);
        amm_rd(3'd6, d); chk("t5_sent", d, 2);

        // Asynchronous reset mid-packet, then a clean restart.
        configure(64, 0, 1, 1'b0, 32'h0, 32'h0, 32'h0);
        push_pkts(1);
        base = sop_seen;
        start();
        wait_sop("t6_sop", base + 1, 100);
        repeat (2) @(negedge clk_i);
        #2;
        srst_i = 1'b1;
        #1;
        chk("t6_async_valid", src_valid, 0);
        chk("t6_async_outputs", {src_data, src_sop, src_eop, src_empty, src_channel}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #2;
        srst_i = 1'b0;
        amm_rd(3'd6, d); chk("t6_sent_cleared", d, 0);
        amm_rd(3'd1, d); chk("t6_len_cleared", d, 0);
        configure(12, 3, 1, 1'b1, 32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB);
        push_pkts(1);
        start();
        wait_done("t6_drain", 100);
        amm_rd(3'd6, d); chk("t6_sent", d, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
